// File: rtl/mem_access_ctrl.sv
// M-stage load/store sequencer: issues one req/ack transaction per memory instruction,
// stalls the pipeline while it is outstanding and raises a sticky bus error on timeout.
module mem_access_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MemWriteM,
  input  logic [1:0]       ResultSrcM,
  input  logic [2:0]       TypeM,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] WriteDataM,
  output logic             MemReq,
  output logic             MemWe,
  output logic [WIDTH-1:0] MemAddr,
  output logic [WIDTH-1:0] MemWData,
  output logic [2:0]       MemType,
  input  logic             MemAck,
  input  logic [WIDTH-1:0] MemRData,
  output logic [WIDTH-1:0] ReadDataM,
  output logic             StallM,
  output logic             BusErr,
  output logic [1:0]       fsm_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          access;
  logic          timed_out;

  // A combined store+load encoding is sequenced as a store.
  assign access    = MemWriteM | (ResultSrcM == 2'b01);
  assign timed_out = (cnt == CW'(TIMEOUT - 1));
  assign fsm_state = state;

  // Stall is combinational so the detection cycle in IDLE already freezes the pipeline.
  always_comb begin
    StallM = 1'b0;
    if (!RST) begin
      StallM = ((state == IDLE) && access) || (state == WAIT);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      MemReq    <= 1'b0;
      MemWe     <= 1'b0;
      MemAddr   <= '0;
      MemWData  <= '0;
      MemType   <= '0;
      ReadDataM <= '0;
      BusErr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            MemAddr  <= ALUResultM;
            MemWData <= WriteDataM;
            MemType  <= TypeM;
            MemWe    <= MemWriteM;
            cnt      <= '0;
            MemReq   <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (MemAck) begin
            if (!MemWe) ReadDataM <= MemRData;
            MemReq <= 1'b0;
            state  <= DONE;
          end else if (timed_out) begin
            BusErr <= 1'b1;
            if (!MemWe) ReadDataM <= '0;
            MemReq <= 1'b0;
            state  <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          MemReq <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a driver issues accesses and queues the expected
// completion; a monitor checks each completion in the DONE cycle against the queue head.
module tb_mem_access_ctrl;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 15;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             MemWriteM = 1'b0;
  logic [1:0]       ResultSrcM = 2'b00;
  logic [2:0]       TypeM = 3'b000;
  logic [WIDTH-1:0] ALUResultM = '0;
  logic [WIDTH-1:0] WriteDataM = '0;
  logic             MemReq;
  logic             MemWe;
  logic [WIDTH-1:0] MemAddr;
  logic [WIDTH-1:0] MemWData;
  logic [2:0]       MemType;
  logic             MemAck = 1'b0;
  logic [WIDTH-1:0] MemRData = '0;
  logic [WIDTH-1:0] ReadDataM;
  logic             StallM;
  logic             BusErr;
  logic [1:0]       fsm_state;

  mem_access_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .TypeM(TypeM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .MemReq(MemReq), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemType(MemType), .MemAck(MemAck),
    .MemRData(MemRData), .ReadDataM(ReadDataM), .StallM(StallM), .BusErr(BusErr),
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- checking state ----------------
  typedef struct packed {
    logic [31:0] rdata;
    logic        berr;
    logic [7:0]  req_cycles;
    logic [7:0]  stall_cycles;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [2:0]  typ;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // ---------------- memory model ----------------
  int          mem_lat  = 1;
  logic [31:0] mem_data = '0;
  logic        spur     = 1'b0;
  int          wcnt     = 0;

  always @(negedge CLK) begin
    if (MemReq) begin
      wcnt++;
      MemAck   = (mem_lat != 0) && (wcnt == mem_lat);
      MemRData = MemAck ? mem_data : 32'hBAD0BAD0;
    end else begin
      wcnt     = 0;
      MemAck   = spur;
      MemRData = 32'hFFFF0000;
    end
  end

  // ---------------- monitor ----------------
  logic prev_req = 1'b0;
  int   req_n = 0, stall_n = 0, bad_bus = 0;

  always @(negedge CLK or posedge RST) begin
    if (RST) begin
      prev_req = 1'b0;
      req_n    = 0;
      stall_n  = 0;
      bad_bus  = 0;
    end else begin
      if (StallM) stall_n++;
      if (MemReq) begin
        req_n++;
        if (exp_q.size() > 0) begin
          if ({MemAddr, MemWData, MemWe, MemType} !==
              {exp_q[0].addr, exp_q[0].wdata, exp_q[0].we, exp_q[0].typ}) bad_bus++;
        end
      end
      if (prev_req && !MemReq) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("read_data", ReadDataM, e.rdata);
          check("bus_err", {31'd0, BusErr}, {31'd0, e.berr});
          check("req_cycles", req_n, {24'd0, e.req_cycles});
          check("stall_cycles", stall_n, {24'd0, e.stall_cycles});
          check("bus_stable", bad_bus, 32'd0);
          check("done_stall", {31'd0, StallM}, 32'd0);
        end
        done_cnt++;
        req_n   = 0;
        stall_n = 0;
        bad_bus = 0;
      end
      prev_req = MemReq;
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the edge that ends DONE.
  task automatic do_access(input logic we, input logic ld, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] typ, input int lat,
                           input logic [31:0] mdata, input logic [31:0] exp_rd,
                           input logic exp_be);
    exp_t e;
    int   start;
    e.rdata        = exp_rd;
    e.berr         = exp_be;
    e.req_cycles   = (lat == 0) ? 8'(TIMEOUT) : 8'(lat);
    e.stall_cycles = e.req_cycles + 8'd1;
    e.addr         = addr;
    e.wdata        = wdata;
    e.we           = we;
    e.typ          = typ;
    exp_q.push_back(e);
    mem_lat    = lat;
    mem_data   = mdata;
    MemWriteM  = we;
    ResultSrcM = ld ? 2'b01 : 2'b00;
    ALUResultM = addr;
    WriteDataM = wdata;
    TypeM      = typ;
    start      = done_cnt;
    for (int i = 0; i < 60 && done_cnt == start; i++) begin
      @(negedge CLK);
      #1;
    end
    if (done_cnt == start) begin
      check("done_wait", 32'd0, 32'd1);
      exp_q.delete();
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b00;
    ALUResultM = '0;
    WriteDataM = '0;
    TypeM      = 3'b000;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ResultSrcM = 2'b01;
    #7;
    check("rst_stall", {31'd0, StallM}, 32'd0);
    check("rst_req", {31'd0, MemReq}, 32'd0);
    check("rst_we", {31'd0, MemWe}, 32'd0);
    check("rst_addr", MemAddr, 32'd0);
    check("rst_wdata", MemWData, 32'd0);
    check("rst_type", {29'd0, MemType}, 32'd0);
    check("rst_rdata", ReadDataM, 32'd0);
    check("rst_buserr", {31'd0, BusErr}, 32'd0);
    check("rst_state", {30'd0, fsm_state}, 32'd0);
    ResultSrcM = 2'b00;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idle(1);

    // load, ack in first WAIT cycle
    do_access(1'b0, 1'b1, 32'h100, 32'h0, 3'b010, 1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    idle(2);
    // store, ack in 4th WAIT cycle; load data untouched
    do_access(1'b1, 1'b0, 32'h20, 32'h12345678, 3'b010, 4, 32'h0, 32'hDEADBEEF, 1'b0);
    idle(1);
    // store and load flagged together behaves as a store
    do_access(1'b1, 1'b1, 32'h24, 32'hA5A5A5A5, 3'b001, 2, 32'h77777777, 32'hDEADBEEF, 1'b0);
    idle(1);
    // ack in the last allowed WAIT cycle
    do_access(1'b0, 1'b1, 32'h40, 32'h0, 3'b100, 15, 32'hCAFE0001, 32'hCAFE0001, 1'b0);
    idle(1);

    // back-to-back loads with a spurious ack outside WAIT
    spur = 1'b1;
    do_access(1'b0, 1'b1, 32'h0, 32'h0, 3'b010, 1, 32'h11111111, 32'h11111111, 1'b0);
    do_access(1'b0, 1'b1, 32'h4, 32'h0, 3'b010, 2, 32'h22222222, 32'h22222222, 1'b0);
    idle(3);
    check("spur_req", {31'd0, MemReq}, 32'd0);
    check("spur_rdata", ReadDataM, 32'h22222222);
    check("spur_state", {30'd0, fsm_state}, 32'd0);
    spur = 1'b0;

    // timeout, then sticky error across successful accesses
    do_access(1'b0, 1'b1, 32'h80, 32'h0, 3'b010, 0, 32'h0, 32'h0, 1'b1);
    idle(1);
    do_access(1'b0, 1'b1, 32'h84, 32'h0, 3'b010, 3, 32'h00005A5A, 32'h00005A5A, 1'b1);
    idle(1);
    do_access(1'b1, 1'b0, 32'h88, 32'h55AA55AA, 3'b010, 1, 32'h0, 32'h00005A5A, 1'b1);
    idle(1);

    // asynchronous reset in the middle of WAIT
    mem_lat    = 0;
    ResultSrcM = 2'b01;
    ALUResultM = 32'h90;
    repeat (4) @(negedge CLK);
    check("pre_rst_req", {31'd0, MemReq}, 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check("arst_req", {31'd0, MemReq}, 32'd0);
    check("arst_stall", {31'd0, StallM}, 32'd0);
    check("arst_buserr", {31'd0, BusErr}, 32'd0);
    check("arst_state", {30'd0, fsm_state}, 32'd0);
    check("arst_rdata", ReadDataM, 32'd0);
    ResultSrcM = 2'b00;
    ALUResultM = '0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idle(2);
    check("post_rst_state", {30'd0, fsm_state}, 32'd0);
    check("post_rst_req", {31'd0, MemReq}, 32'd0);

    // restart after reset
    do_access(1'b0, 1'b1, 32'h8C, 32'h0, 3'b011, 1, 32'h0BADF00D, 32'h0BADF00D, 1'b0);
    idle(2);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
